microm_exec_ctrl: RTL and testbench
===================================

# microm_exec_ctrl

Instruction sequencer for the Microm integer datapath. It accepts one decoded integer instruction at a time (MOVI, POPI, STORI, COPYI, RCOPYI, RMOVI) and sequences the reads and writes it needs on the integer register file and the integer stack memory. It owns the stack pointer and detects stack underflow and overflow. It sits between the instruction decoder and the integer register file and stack RAM.

## Interface
Parameters:
- DATA_W, 32: register and stack word width.
- NREG, 8: number of integer registers. REG_W = $clog2(NREG).
- DEPTH, 16: number of stack entries. SP_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller idle; the instruction is accepted on valid&&ready.
- instr_op  in  3  opcode, microm_pkg::op_e.
- instr_rs, instr_rd  in  REG_W  source and destination register.
- instr_imm  in  DATA_W  immediate for MOVI.
- rf_raddr  out  REG_W  register-file read address. rf_rdata is valid 1 cycle later.
- rf_rdata  in  DATA_W  register-file read data.
- rf_we, rf_waddr, rf_wdata  out  1/REG_W/DATA_W  register-file write port.
- st_addr  out  $clog2(DEPTH)  stack RAM address. Reads have 1-cycle latency.
- st_we, st_wdata  out  1/DATA_W  stack RAM write.
- st_rdata  in  DATA_W  stack RAM read data.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  qualifies done; the instruction was rejected.
- err_code  out  2  ERR_NONE, ERR_UNDERFLOW, ERR_OVERFLOW.
- sp  out  SP_W  current stack occupancy.

## Operation
- FSM states: IDLE, CHECK, READ, EXEC, CLEAR. instr_ready = (state==IDLE).
- On accept, the controller latches op, rs, rd and imm, then moves to CHECK.
- CHECK:
  - STORI or COPYI with sp==0 gives underflow.
  - POPI or COPYI with sp==DEPTH gives overflow.
  - On error: pulse done and err, set err_code, return to IDLE. No RF or stack write and no sp change.
- MOVI: CHECK goes to EXEC. EXEC writes rd=imm, pulses done, returns to IDLE.
- RCOPYI: READ (rf_raddr=rs), then EXEC writes rd=rf_rdata.
- RMOVI: same as RCOPYI, then CLEAR writes rs=0. If rs==rd, rd ends at 0.
- POPI (push register to stack): READ rs, then EXEC (st_we, st_addr=sp, st_wdata=rf_rdata, sp+1), then CLEAR writes rs=0.
- STORI (pop stack to register): READ (st_addr=sp-1), then EXEC writes rd=st_rdata and sp-1.
- COPYI (duplicate top): READ (st_addr=sp-1), then EXEC (st_we, st_addr=sp, st_wdata=st_rdata, sp+1).
- At most one of rf_we and st_we is asserted per cycle. Write strobes are high only in EXEC and CLEAR.
- Reset, including mid-instruction:
  - Next edge: state=IDLE, sp=0.
  - done, err, rf_we and st_we are 0; err_code=ERR_NONE; addresses and wdata are 0.
  - The in-flight instruction is dropped and produces no further writes.
  - instr_ready is 0 while rst_n is low.
- instr_valid while not ready is ignored. The decoder holds the instruction until it is accepted.

## Timing
- Accept in cycle 0; CHECK in cycle 1.
- MOVI: done in cycle 2.
- RCOPYI, STORI, COPYI: done in cycle 3.
- RMOVI, POPI: done in cycle 4.
- Error: done+err in cycle 1, the CHECK cycle.
- done asserts in the final active state. instr_ready rises the following cycle, so back-to-back throughput is latency+1.
- sp updates on the EXEC edge and is visible from the next cycle.
- done, err and err_code are registered. Each pulse lasts exactly 1 cycle.

## Configuration
- MICROM_STACK_CHK_EN defined:
  - Underflow and overflow checks run in CHECK as described above.
- Not defined:
  - CHECK never flags an error; err and err_code stay 0.
  - sp wraps modulo DEPTH+1.
  - st_addr uses the low address bits.
  - CHECK still costs one cycle, so latencies are identical.

## Structure
- microm_pkg holds:
  - op_e: OP_MOVI=0, OP_POPI=1, OP_STORI=2, OP_COPYI=3, OP_RCOPYI=4, OP_RMOVI=5.
  - err_e.
  - state_e.
- Opcodes 6–7 are illegal: they are treated as a no-op and retire with done only.
- One sub-module, microm_stack_ptr:
  - Holds the sp register with inc and dec inputs, plus empty and full flags.
  - Contains the wrap logic selected by MICROM_STACK_CHK_EN.

## Test plan
- Reset, then MOVI rd=3 imm=0x2A -> rf write r3=0x2A in cycle 2, done in cycle 2, sp=0.
- MOVI r1=7; POPI rs=1 -> stack[0]=7, r1 written 0, sp=1, done in cycle 4.
- With sp=1 (top=7): COPYI -> stack[1]=7, sp=2. Then STORI rd=5 twice -> r5=7 each time, sp=0.
- STORI with sp=0 -> done+err in cycle 1, err_code=UNDERFLOW, no writes. Push DEPTH times, then one more POPI -> OVERFLOW, sp stays DEPTH.
- RMOVI rs=2 rd=2 with r2=9 -> r2 ends 0. RMOVI rs=2 rd=4 with r2=9 -> r4=9, r2=0.
- Assert rst_n=0 during the EXEC cycle of POPI -> no further st_we or rf_we, sp=0, instr_ready=1 the cycle after rst_n rises.

Source files
------------

// File: rtl/microm_pkg.sv
// Shared types for the Microm integer execution controller: opcodes, error codes, FSM states.
// Build option MICROM_STACK_CHK_EN (see microm_stack_ptr / microm_exec_ctrl) enables stack bound checks.
package microm_pkg;

  typedef enum logic [2:0] {
    OP_MOVI   = 3'd0,
    OP_POPI   = 3'd1,
    OP_STORI  = 3'd2,
    OP_COPYI  = 3'd3,
    OP_RCOPYI = 3'd4,
    OP_RMOVI  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // Encodings 6 and 7 are not instructions; they retire as a no-op.
  function automatic logic opIsLegal(input op_e op);
    return (op <= OP_RMOVI);
  endfunction

  // Ops that zero their source register in a trailing CLEAR cycle.
  function automatic logic opHasClear(input op_e op);
    return (op == OP_POPI) || (op == OP_RMOVI);
  endfunction

endpackage

// File: rtl/microm_stack_ptr.sv
// Stack occupancy register with empty/full flags.
// MICROM_STACK_CHK_EN: pointer holds at its bounds; otherwise it wraps modulo DEPTH+1.
module microm_stack_ptr
  import microm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [SP_W-1:0] o_sp,
  output logic [SP_W-1:0] o_spDec,
  output logic            o_empty,
  output logic            o_full
);

  localparam logic [SP_W-1:0] C_DEPTH = SP_W'(DEPTH);

  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_spInc;
  logic [SP_W-1:0] w_spDec;

  assign o_empty = (r_sp == '0);
  assign o_full  = (r_sp == C_DEPTH);

`ifdef MICROM_STACK_CHK_EN
  assign w_spInc = o_full  ? r_sp : r_sp + SP_W'(1);
  assign w_spDec = o_empty ? r_sp : r_sp - SP_W'(1);
`else
  // Unchecked build: occupancy runs over the DEPTH+1 values 0..DEPTH and wraps.
  assign w_spInc = o_full  ? '0      : r_sp + SP_W'(1);
  assign w_spDec = o_empty ? C_DEPTH : r_sp - SP_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (i_inc && !i_dec) begin
      r_sp <= w_spInc;
    end else if (i_dec && !i_inc) begin
      r_sp <= w_spDec;
    end
  end

  assign o_sp    = r_sp;
  assign o_spDec = w_spDec;

endmodule

// File: rtl/microm_exec_ctrl.sv
// Microm integer instruction sequencer: drives register-file and stack-RAM ports for one instruction at a time.
// MICROM_STACK_CHK_EN enables underflow/overflow rejection in CHECK.
module microm_exec_ctrl
  import microm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int DEPTH  = 16,
  parameter int REG_W  = $clog2(NREG),
  parameter int SP_W   = $clog2(DEPTH + 1),
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  op_e               instr_op,
  input  logic [REG_W-1:0]  instr_rs,
  input  logic [REG_W-1:0]  instr_rd,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [REG_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [AW-1:0]     st_addr,
  output logic              st_we,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] st_rdata,
  output logic              done,
  output logic              err,
  output err_e              err_code,
  output logic [SP_W-1:0]   sp
);

`ifdef MICROM_STACK_CHK_EN
  localparam bit C_CHK = 1'b1;
`else
  localparam bit C_CHK = 1'b0;
`endif

  state_e            r_state;
  op_e               r_op;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_imm;
  logic              r_earlyRetire;
  logic              r_done;
  logic              r_err;
  err_e              r_errCode;

  logic              w_accept;
  logic              w_underflow;
  logic              w_overflow;
  logic              w_reject;
  logic              w_earlyRetire;
  logic              w_inc;
  logic              w_dec;
  logic [SP_W-1:0]   w_sp;
  logic [SP_W-1:0]   w_spDec;
  logic              w_empty;
  logic              w_full;

  assign instr_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept    = instr_valid && instr_ready;

  // sp is stable between accept and CHECK, so the bound check is evaluated at accept and
  // registered so that done/err appear in the CHECK cycle.
  assign w_underflow   = C_CHK && ((instr_op == OP_STORI) || (instr_op == OP_COPYI)) && w_empty;
  assign w_overflow    = C_CHK && ((instr_op == OP_POPI)  || (instr_op == OP_COPYI)) && w_full;
  assign w_reject      = w_underflow || w_overflow;
  assign w_earlyRetire = w_reject || !opIsLegal(instr_op);

  assign w_inc = (r_state == ST_EXEC) && ((r_op == OP_POPI) || (r_op == OP_COPYI));
  assign w_dec = (r_state == ST_EXEC) && (r_op == OP_STORI);

  microm_stack_ptr #(
    .DEPTH (DEPTH),
    .SP_W  (SP_W)
  ) u_stackPtr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_sp    (w_sp),
    .o_spDec (w_spDec),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_MOVI;
      r_rs          <= '0;
      r_rd          <= '0;
      r_imm         <= '0;
      r_earlyRetire <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_errCode     <= ERR_NONE;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_errCode <= ERR_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op          <= instr_op;
            r_rs          <= instr_rs;
            r_rd          <= instr_rd;
            r_imm         <= instr_imm;
            r_earlyRetire <= w_earlyRetire;
            r_state       <= ST_CHECK;
            if (w_earlyRetire) begin
              r_done    <= 1'b1;
              r_err     <= w_reject;
              r_errCode <= w_underflow ? ERR_UNDERFLOW :
                           w_overflow  ? ERR_OVERFLOW  : ERR_NONE;
            end
          end
        end
        ST_CHECK: begin
          if (r_earlyRetire) begin
            r_state <= ST_IDLE;
          end else if (r_op == OP_MOVI) begin
            r_state <= ST_EXEC;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_state <= ST_EXEC;
          r_done  <= !opHasClear(r_op);
        end
        ST_EXEC: begin
          if (opHasClear(r_op)) begin
            r_state <= ST_CLEAR;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side ports decode from the state register; write data must pass read data straight
  // through because both memories return it in the EXEC cycle.
  always_comb begin
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    st_addr  = '0;
    st_we    = 1'b0;
    st_wdata = '0;
    if (rst_n) begin
      case (r_state)
        ST_READ: begin
          case (r_op)
            OP_RCOPYI, OP_RMOVI, OP_POPI: rf_raddr = r_rs;
            OP_STORI, OP_COPYI:           st_addr  = w_spDec[AW-1:0];
            default: ;
          endcase
        end
        ST_EXEC: begin
          case (r_op)
            OP_MOVI: begin
              rf_we    = 1'b1;
              rf_waddr = r_rd;
              rf_wdata = r_imm;
            end
            OP_RCOPYI, OP_RMOVI: begin
              rf_we    = 1'b1;
              rf_waddr = r_rd;
              rf_wdata = rf_rdata;
            end
            OP_STORI: begin
              rf_we    = 1'b1;
              rf_waddr = r_rd;
              rf_wdata = st_rdata;
            end
            OP_POPI: begin
              st_we    = 1'b1;
              st_addr  = w_sp[AW-1:0];
              st_wdata = rf_rdata;
            end
            OP_COPYI: begin
              st_we    = 1'b1;
              st_addr  = w_sp[AW-1:0];
              st_wdata = st_rdata;
            end
            default: ;
          endcase
        end
        ST_CLEAR: begin
          rf_we    = 1'b1;
          rf_waddr = r_rs;
          rf_wdata = '0;
        end
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_errCode;
  assign sp       = w_sp;

endmodule

// File: tb/tb_microm_exec_ctrl.sv
// Directed bench for microm_exec_ctrl with register-file and stack RAM models and a write/retire scoreboard.
// Expectations follow MICROM_STACK_CHK_EN when it is defined for the build.
module tb_microm_exec_ctrl;
  import microm_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int DEPTH  = 16;
  localparam int REG_W  = 3;
  localparam int SP_W   = 5;
  localparam int AW     = 4;

`ifdef MICROM_STACK_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  op_e               instr_op;
  logic [REG_W-1:0]  instr_rs;
  logic [REG_W-1:0]  instr_rd;
  logic [DATA_W-1:0] instr_imm;
  logic [REG_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [AW-1:0]     st_addr;
  logic              st_we;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] st_rdata;
  logic              done;
  logic              err;
  err_e              err_code;
  logic [SP_W-1:0]   sp;

  always #5 clk = ~clk;

  microm_exec_ctrl #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rs    (instr_rs),
    .instr_rd    (instr_rd),
    .instr_imm   (instr_imm),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .st_addr     (st_addr),
    .st_we       (st_we),
    .st_wdata    (st_wdata),
    .st_rdata    (st_rdata),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .sp          (sp)
  );

  // Memories with 1-cycle read latency, cleared while memClear is high.
  logic              memClear;
  logic [DATA_W-1:0] memRf [NREG];
  logic [DATA_W-1:0] memSt [DEPTH];

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < NREG; i++)  memRf[i] <= '0;
      for (int i = 0; i < DEPTH; i++) memSt[i] <= '0;
      rf_rdata <= '0;
      st_rdata <= '0;
    end else begin
      rf_rdata <= memRf[rf_raddr];
      st_rdata <= memSt[st_addr];
      if (rf_we) memRf[rf_waddr] <= rf_wdata;
      if (st_we) memSt[st_addr]  <= st_wdata;
    end
  end

  typedef struct packed {
    logic        isSt;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [7:0] lat;
  } ret_t;

  wr_t  expWr[$];
  ret_t expRet[$];

  int          nVectors;
  int          nMiss;
  logic [31:0] shRf [NREG];
  logic [31:0] shSt [DEPTH];
  int          shSp;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiss++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWr(input logic isSt, input int addr, input logic [31:0] data);
    wr_t w;
    w.isSt = isSt;
    w.addr = 4'(addr);
    w.data = data;
    expWr.push_back(w);
  endtask

  // Predict writes/retirement from the shadow model, issue one instruction, then track it to retirement.
  task automatic applyStimulus(input logic [2:0] opBits, input int rs, input int rd, input logic [31:0] imm);
    ret_t        r;
    ret_t        got;
    wr_t         obsW;
    wr_t         expW;
    logic [31:0] v;
    int          wrAddr;
    int          rdAddr;
    int          expN;
    int          nWr;
    bit          seen;
    r.err  = 1'b0;
    r.code = 2'd0;
    r.lat  = 8'd1;
    wrAddr = shSp % DEPTH;
    rdAddr = ((shSp + DEPTH) % (DEPTH + 1)) % DEPTH;
    case (opBits)
      3'd0: begin
        pushWr(1'b0, rd, imm); shRf[rd] = imm; r.lat = 8'd2;
      end
      3'd1: begin
        if (CHK && shSp == DEPTH) begin
          r.err = 1'b1; r.code = 2'd2;
        end else begin
          v = shRf[rs];
          pushWr(1'b1, wrAddr, v); pushWr(1'b0, rs, 32'd0);
          shSt[wrAddr] = v; shRf[rs] = 32'd0;
          shSp = (shSp + 1) % (DEPTH + 1); r.lat = 8'd4;
        end
      end
      3'd2: begin
        if (CHK && shSp == 0) begin
          r.err = 1'b1; r.code = 2'd1;
        end else begin
          v = shSt[rdAddr];
          pushWr(1'b0, rd, v); shRf[rd] = v;
          shSp = (shSp + DEPTH) % (DEPTH + 1); r.lat = 8'd3;
        end
      end
      3'd3: begin
        if (CHK && shSp == 0) begin
          r.err = 1'b1; r.code = 2'd1;
        end else if (CHK && shSp == DEPTH) begin
          r.err = 1'b1; r.code = 2'd2;
        end else begin
          v = shSt[rdAddr];
          pushWr(1'b1, wrAddr, v); shSt[wrAddr] = v;
          shSp = (shSp + 1) % (DEPTH + 1); r.lat = 8'd3;
        end
      end
      3'd4: begin
        v = shRf[rs]; pushWr(1'b0, rd, v); shRf[rd] = v; r.lat = 8'd3;
      end
      3'd5: begin
        v = shRf[rs];
        pushWr(1'b0, rd, v); pushWr(1'b0, rs, 32'd0);
        shRf[rd] = v; shRf[rs] = 32'd0; r.lat = 8'd4;
      end
      default: ;
    endcase
    expRet.push_back(r);
    expN = expWr.size();

    checkOutput("ready_before_issue", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op_e'(opBits);
    instr_rs    = REG_W'(rs);
    instr_rd    = REG_W'(rd);
    instr_imm   = imm;
    @(posedge clk);
    #1 instr_valid = 1'b0;

    seen = 1'b0;
    nWr  = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      checkOutput("single_strobe", rf_we & st_we, 0);
      if (rf_we === 1'b1 || st_we === 1'b1) begin
        nWr++;
        obsW.isSt = (rf_we !== 1'b1);
        obsW.addr = (rf_we === 1'b1) ? 4'(rf_waddr) : 4'(st_addr);
        obsW.data = (rf_we === 1'b1) ? rf_wdata : st_wdata;
        if (expWr.size() > 0) begin
          expW = expWr.pop_front();
          checkOutput("write_txn", obsW, expW);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        got.err  = err;
        got.code = err_code;
        got.lat  = 8'(c);
        r = expRet.pop_front();
        checkOutput("retire_err_code_lat", got, r);
      end
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("write_count", nWr, expN);
    expWr.delete();
    expRet.delete();

    @(negedge clk);
    checkOutput("ready_after_done", instr_ready, 1);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("sp_after", sp, shSp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nVectors = 0;
    nMiss    = 0;
    shSp     = 0;
    for (int i = 0; i < NREG; i++)  shRf[i] = '0;
    for (int i = 0; i < DEPTH; i++) shSt[i] = '0;
    rst_n       = 1'b0;
    memClear    = 1'b1;
    instr_valid = 1'b0;
    instr_op    = OP_MOVI;
    instr_rs    = '0;
    instr_rd    = '0;
    instr_imm   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_low", instr_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_sp", sp, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_st_we", st_we, 0);
    rst_n    = 1'b1;
    memClear = 1'b0;
    @(negedge clk);

    // Basic MOVI, then push a register and duplicate/pop the stack.
    applyStimulus(3'd0, 0, 3, 32'h2A);
    applyStimulus(3'd0, 0, 1, 32'h7);
    applyStimulus(3'd1, 1, 0, 32'h0);
    applyStimulus(3'd3, 0, 0, 32'h0);
    applyStimulus(3'd2, 0, 5, 32'h0);
    applyStimulus(3'd2, 0, 5, 32'h0);
    checkOutput("r5_popped", memRf[5], 32'h7);

    // Empty-stack pops, fill to DEPTH, push past full, then drain a few.
    applyStimulus(3'd2, 0, 5, 32'h0);
    applyStimulus(3'd3, 0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(3'd0, 0, 6, 32'h100 + 32'(i));
      applyStimulus(3'd1, 6, 0, 32'h0);
    end
    applyStimulus(3'd0, 0, 6, 32'hABCD);
    applyStimulus(3'd1, 6, 0, 32'h0);
    applyStimulus(3'd3, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(3'd2, 0, 7, 32'h0);

    // Register moves, including rs==rd.
    applyStimulus(3'd0, 0, 2, 32'h9);
    applyStimulus(3'd5, 2, 2, 32'h0);
    checkOutput("rmovi_same_reg", memRf[2], 32'h0);
    applyStimulus(3'd0, 0, 2, 32'h9);
    applyStimulus(3'd5, 2, 4, 32'h0);
    checkOutput("rmovi_dst", memRf[4], 32'h9);
    checkOutput("rmovi_src", memRf[2], 32'h0);
    applyStimulus(3'd4, 4, 0, 32'h0);

    // Illegal opcodes retire without effect.
    applyStimulus(3'd6, 1, 2, 32'hFFFF);
    applyStimulus(3'd7, 3, 4, 32'h1234);

    // Reset landing in the EXEC cycle of a POPI.
    applyStimulus(3'd0, 0, 1, 32'h55);
    checkOutput("ready_before_popi", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = OP_POPI;
    instr_rs    = 3'd1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("popi_in_exec", st_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rf_we", rf_we, 0);
    checkOutput("midrst_st_we", st_we, 0);
    checkOutput("midrst_sp", sp, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ready_low", instr_ready, 0);
    rst_n = 1'b1;
    shSp  = 0;
    @(negedge clk);
    checkOutput("postrst_ready", instr_ready, 1);
    checkOutput("postrst_rf_we", rf_we, 0);
    checkOutput("postrst_st_we", st_we, 0);
    checkOutput("postrst_done", done, 0);
    applyStimulus(3'd4, 1, 0, 32'h0);
    checkOutput("r1_not_cleared", memRf[0], 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
